// File: rtl/fpro_arb_pkg.sv
// Shared types and constants for the two-master FPro MMIO arbiter.
package fpro_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 21;
    localparam int DEF_DATA_W = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant: round-robin on last grant, or fixed priority to master 0.
module rr_arb2
    import fpro_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_i,
    input  logic       fixed_prio_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    logic [1:0] eff_req_s;

    // Resolve the winner among unmasked requesters
    always_comb begin
        eff_req_s = req_i & ~mask_i;
        gnt_vld_o = |eff_req_s;
        case (eff_req_s)
            2'b01:   gnt_idx_o = M0;
            2'b10:   gnt_idx_o = M1;
            2'b11:   gnt_idx_o = fixed_prio_i ? M0 : ~last_i;
            default: gnt_idx_o = M0;
        endcase
    end

endmodule

// File: rtl/fpro_mmio_arbiter.sv
// Shares the FPro MMIO bus between two masters: one-cycle registered strobe, then one-cycle ack.
module fpro_mmio_arbiter
    import fpro_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              fp_mmio_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_wr_data,
    input  logic [DATA_W-1:0] fp_rd_data
);

    arb_state_t        state_q;
    logic              sel_q;
    logic              last_q;
    logic              m0_ack_q, m1_ack_q;
    logic [DATA_W-1:0] m0_rd_q, m1_rd_q;
    logic              cs_q, wr_q, rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        mask_s;
    logic              gnt_vld_s;
    logic              gnt_idx_s;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // In ACK the master being acknowledged is still holding req; keep it out of the grant
    always_comb begin
        if (state_q == ACK) begin
            mask_s = sel_q ? 2'b10 : 2'b01;
        end else begin
            mask_s = 2'b00;
        end
    end

    rr_arb2 u_arb (
        .req_i        ({m1_req, m0_req}),
        .mask_i       (mask_s),
        .last_i       (last_q),
        .fixed_prio_i (FIXED_PRIO != 0),
        .gnt_vld_o    (gnt_vld_s),
        .gnt_idx_o    (gnt_idx_s)
    );

    // Request fields of the prospective winner
    always_comb begin
        if (gnt_idx_s == M1) begin
            wr_d    = m1_wr;
            addr_d  = m1_addr;
            wdata_d = m1_wr_data;
        end else begin
            wr_d    = m0_wr;
            addr_d  = m0_addr;
            wdata_d = m0_wr_data;
        end
    end

    // Arbiter FSM with registered bus strobes, acks and captured read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= M0;
            last_q   <= M1;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_rd_q  <= '0;
            m1_rd_q  <= '0;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE, ACK: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    if (gnt_vld_s) begin
                        state_q <= BUS;
                        sel_q   <= gnt_idx_s;
                        last_q  <= gnt_idx_s;
                        cs_q    <= 1'b1;
                        wr_q    <= wr_d;
                        rd_q    <= ~wr_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUS: begin
                    state_q <= ACK;
                    cs_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    if (sel_q == M1) begin
                        m1_ack_q <= 1'b1;
                        if (rd_q) begin
                            m1_rd_q <= fp_rd_data;
                        end else begin
                            m1_rd_q <= m1_rd_q;
                        end
                    end else begin
                        m0_ack_q <= 1'b1;
                        if (rd_q) begin
                            m0_rd_q <= fp_rd_data;
                        end else begin
                            m0_rd_q <= m0_rd_q;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cs_q     <= 1'b0;
                    wr_q     <= 1'b0;
                    rd_q     <= 1'b0;
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign m0_rd_data = m0_rd_q;
    assign m1_rd_data = m1_rd_q;
    assign fp_mmio_cs = cs_q;
    assign fp_wr      = wr_q;
    assign fp_rd      = rd_q;
    assign fp_addr    = addr_q;
    assign fp_wr_data = wdata_q;

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven by the same two masters.
module tb_fpro_mmio_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [20:0] m0_addr, m1_addr;
    logic [31:0] m0_wr_data, m1_wr_data;
    logic [31:0] rd_base;

    logic        rr_m0_ack, rr_m1_ack, rr_cs, rr_wr, rr_rd;
    logic [31:0] rr_m0_rd, rr_m1_rd, rr_wdata, rr_fp_rd;
    logic [20:0] rr_addr;
    logic        fx_m0_ack, fx_m1_ack, fx_cs, fx_wr, fx_rd;
    logic [31:0] fx_m0_rd, fx_m1_rd, fx_wdata, fx_fp_rd;
    logic [20:0] fx_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // mmio_sys model: read data is a fixed pattern XOR the address
    assign rr_fp_rd = rd_base ^ {11'd0, rr_addr};
    assign fx_fp_rd = rd_base ^ {11'd0, fx_addr};

    fpro_mmio_arbiter #(.ADDR_W(21), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(rr_m0_ack), .m0_rd_data(rr_m0_rd),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(rr_m1_ack), .m1_rd_data(rr_m1_rd),
        .fp_mmio_cs(rr_cs), .fp_wr(rr_wr), .fp_rd(rr_rd), .fp_addr(rr_addr),
        .fp_wr_data(rr_wdata), .fp_rd_data(rr_fp_rd)
    );

    fpro_mmio_arbiter #(.ADDR_W(21), .DATA_W(32), .FIXED_PRIO(1)) dut_fx (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(fx_m0_ack), .m0_rd_data(fx_m0_rd),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(fx_m1_ack), .m1_rd_data(fx_m1_rd),
        .fp_mmio_cs(fx_cs), .fp_wr(fx_wr), .fp_rd(fx_rd), .fp_addr(fx_addr),
        .fp_wr_data(fx_wdata), .fp_rd_data(fx_fp_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string tag, input logic [31:0] o_rr, input logic [31:0] o_fx,
                            input logic [31:0] exp);
        chk({tag, "_rr"}, o_rr, exp);
        chk({tag, "_fx"}, o_fx, exp);
    endtask

    // Protocol invariants checked every cycle on both instances
    logic rr_prev_cs = 1'b0, fx_prev_cs = 1'b0, prev_rst = 1'b1;
    always @(negedge clk) begin
        chk("inv_wr_rd_rr", {31'd0, rr_wr & rr_rd}, 32'd0);
        chk("inv_wr_rd_fx", {31'd0, fx_wr & fx_rd}, 32'd0);
        chk("inv_2ack_rr", {31'd0, rr_m0_ack & rr_m1_ack}, 32'd0);
        chk("inv_2ack_fx", {31'd0, fx_m0_ack & fx_m1_ack}, 32'd0);
        chk("inv_cs_ack_rr", {31'd0, rr_m0_ack | rr_m1_ack}, {31'd0, rr_prev_cs & ~prev_rst});
        chk("inv_cs_ack_fx", {31'd0, fx_m0_ack | fx_m1_ack}, {31'd0, fx_prev_cs & ~prev_rst});
        rr_prev_cs = rr_cs;
        fx_prev_cs = fx_cs;
        prev_rst   = reset;
    end

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 21'd0; m0_wr_data = 32'd0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 21'd0; m1_wr_data = 32'd0;
        rd_base = 32'hDEAD_BEFF;
        tick();
        tick();
        chk_both("rst_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd0);
        chk_both("rst_wr", {31'd0, rr_wr}, {31'd0, fx_wr}, 32'd0);
        chk_both("rst_rd", {31'd0, rr_rd}, {31'd0, fx_rd}, 32'd0);
        chk_both("rst_addr", {11'd0, rr_addr}, {11'd0, fx_addr}, 32'd0);
        chk_both("rst_wdata", rr_wdata, fx_wdata, 32'd0);
        chk_both("rst_m0_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd0);
        chk_both("rst_m1_ack", {31'd0, rr_m1_ack}, {31'd0, fx_m1_ack}, 32'd0);
        chk_both("rst_m0_rd", rr_m0_rd, fx_m0_rd, 32'd0);
        chk_both("rst_m1_rd", rr_m1_rd, fx_m1_rd, 32'd0);
        reset = 1'b0;
        tick();
        chk_both("idle_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd0);

        // Single read by master 0; address 0x10 returns 0xDEADBEEF
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00010; m0_wr_data = 32'h5555_5555;
        tick();
        m0_addr = 21'h00003;
        chk_both("rd_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd1);
        chk_both("rd_rd", {31'd0, rr_rd}, {31'd0, fx_rd}, 32'd1);
        chk_both("rd_wr", {31'd0, rr_wr}, {31'd0, fx_wr}, 32'd0);
        chk_both("rd_addr", {11'd0, rr_addr}, {11'd0, fx_addr}, 32'h0000_0010);
        chk_both("rd_early_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd0);
        tick();
        chk_both("rd_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd1);
        chk_both("rd_data", rr_m0_rd, fx_m0_rd, 32'hDEAD_BEEF);
        chk_both("rd_m1_ack", {31'd0, rr_m1_ack}, {31'd0, fx_m1_ack}, 32'd0);
        chk_both("rd_ack_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd0);
        m0_req = 1'b0;
        tick();
        chk_both("rd_ack_done", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd0);

        // Single write by master 1
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00200; m1_wr_data = 32'h0000_00A5;
        tick();
        m1_wr_data = 32'h0000_0077;
        chk_both("wr_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd1);
        chk_both("wr_wr", {31'd0, rr_wr}, {31'd0, fx_wr}, 32'd1);
        chk_both("wr_rd", {31'd0, rr_rd}, {31'd0, fx_rd}, 32'd0);
        chk_both("wr_addr", {11'd0, rr_addr}, {11'd0, fx_addr}, 32'h0000_0200);
        chk_both("wr_wdata", rr_wdata, fx_wdata, 32'h0000_00A5);
        tick();
        chk_both("wr_ack", {31'd0, rr_m1_ack}, {31'd0, fx_m1_ack}, 32'd1);
        chk_both("wr_rd_keep", rr_m1_rd, fx_m1_rd, 32'd0);
        chk_both("wr_m0_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd0);
        m1_req = 1'b0;
        tick();

        // Contention from IDLE after an M1 grant: both pick M0, then strict alternation
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00001;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00002;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk_both("ct_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd1);
                chk_both("ct_addr", {11'd0, rr_addr}, {11'd0, fx_addr},
                         (i % 4 == 0) ? 32'd1 : 32'd2);
                chk_both("ct_m0_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd0);
                chk_both("ct_m1_ack", {31'd0, rr_m1_ack}, {31'd0, fx_m1_ack}, 32'd0);
            end else begin
                chk_both("ct_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd0);
                chk_both("ct_m0_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack},
                         (i % 4 == 1) ? 32'd1 : 32'd0);
                chk_both("ct_m1_ack", {31'd0, rr_m1_ack}, {31'd0, fx_m1_ack},
                         (i % 4 == 3) ? 32'd1 : 32'd0);
            end
        end
        chk_both("ct_m0_data", rr_m0_rd, fx_m0_rd, 32'hDEAD_BEFE);
        chk_both("ct_m1_data", rr_m1_rd, fx_m1_rd, 32'hDEAD_BEFD);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        chk_both("ct_idle_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd0);

        // Leave M0 as the last grant, then contend from IDLE: policies diverge
        m0_req = 1'b1;
        tick();
        tick();
        m0_req = 1'b0;
        tick();
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        chk("pol_first_rr", {11'd0, rr_addr}, 32'd2);
        chk("pol_first_fx", {11'd0, fx_addr}, 32'd1);
        tick();
        chk("pol_ack_rr", {30'd0, rr_m1_ack, rr_m0_ack}, 32'd2);
        chk("pol_ack_fx", {30'd0, fx_m1_ack, fx_m0_ack}, 32'd1);
        tick();
        chk("pol_second_rr", {11'd0, rr_addr}, 32'd1);
        chk("pol_second_fx", {11'd0, fx_addr}, 32'd2);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        chk("pol_ack2_rr", {30'd0, rr_m1_ack, rr_m0_ack}, 32'd1);
        chk("pol_ack2_fx", {30'd0, fx_m1_ack, fx_m0_ack}, 32'd2);
        tick();

        // Reset during the BUS cycle of an m0 read abandons it without ack
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00010;
        tick();
        chk_both("mr_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd1);
        reset = 1'b1;
        tick();
        chk_both("mr_cs_off", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd0);
        chk_both("mr_rd_off", {31'd0, rr_rd}, {31'd0, fx_rd}, 32'd0);
        chk_both("mr_addr", {11'd0, rr_addr}, {11'd0, fx_addr}, 32'd0);
        chk_both("mr_no_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd0);
        chk_both("mr_rd_clr", rr_m0_rd, fx_m0_rd, 32'd0);
        reset = 1'b0;
        tick();
        chk_both("mr_retry_cs", {31'd0, rr_cs}, {31'd0, fx_cs}, 32'd1);
        chk_both("mr_retry_addr", {11'd0, rr_addr}, {11'd0, fx_addr}, 32'h0000_0010);
        tick();
        chk_both("mr_retry_ack", {31'd0, rr_m0_ack}, {31'd0, fx_m0_ack}, 32'd1);
        chk_both("mr_retry_data", rr_m0_rd, fx_m0_rd, 32'hDEAD_BEEF);
        m0_req = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpro_mmio_arbiter.md
Name: fpro_mmio_arbiter

Overview:
- Shares the single FPro MMIO bus (cs/wr/rd/addr/wr_data/rd_data) between two bus masters.
- Master 0 is the MicroBlaze MCS bridge. Master 1 is a secondary master, such as a DMA or debug engine.
- Sits between the masters and mmio_sys. Registers the bus strobes, captures read data, and returns a one-cycle ack per transaction.
- Arbitration is round-robin or fixed-priority, chosen by parameter.

Parameters:
- ADDR_W, 21, MMIO word address width (matches fp_addr).
- DATA_W, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins contention.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- m0_req  in  1  master 0 transaction request, held until m0_ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  target address
- m0_wr_data  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rd_data  out  DATA_W  read data, valid when m0_ack=1
- m1_req, m1_wr, m1_addr, m1_wr_data, m1_ack, m1_rd_data: same as master 0, for master 1
- fp_mmio_cs  out  1  MMIO chip select (registered)
- fp_wr  out  1  write strobe (registered)
- fp_rd  out  1  read strobe (registered)
- fp_addr  out  ADDR_W  registered address
- fp_wr_data  out  DATA_W  registered write data
- fp_rd_data  in  DATA_W  combinational read data from mmio_sys, valid in the strobe cycle

Behaviour:
- Single clock clk. Reset is synchronous, active-high, on port reset.
- Reset values:
  - All outputs are 0.
  - State = IDLE.
  - Round-robin pointer favours master 0.
  - Captured read data = 0.
- FSM states: IDLE, BUS, ACK.
- IDLE:
  - If any req is high, the arbiter picks a winner, latches its wr/addr/wr_data into the bus registers, and goes to BUS.
  - Otherwise it stays in IDLE.
- BUS (exactly one cycle):
  - fp_mmio_cs=1. fp_wr=wr. fp_rd=~wr. fp_addr and fp_wr_data hold the latched values.
  - fp_rd_data is captured into the winner's rd_data register (reads only; on writes the rd_data register is left unchanged).
  - Next state is ACK.
- ACK (exactly one cycle):
  - The winner's ack=1 and its rd_data is valid.
  - All fp_* strobes are 0 (fp_addr and fp_wr_data may hold their values).
  - The winner's req is ignored this cycle, because the master drops it after seeing ack.
  - If the other master's req=1, the arbiter grants it directly and goes to BUS. Otherwise it goes to IDLE.
- Latency:
  - req rises in cycle N (arbiter in IDLE): strobe in N+1, ack in N+2.
  - Back-to-back throughput is one transaction every 2 cycles when alternating masters.
- Arbitration with both req=1 in IDLE:
  - FIXED_PRIO=1: master 0 wins.
  - FIXED_PRIO=0: the master not granted last wins. The pointer updates on every grant.
- Single requester: it wins regardless of the pointer.
- Request inputs are sampled only at grant. Changing addr/wr/wr_data after grant has no effect on the transaction.
- Dropping req before ack is a protocol violation; the transaction still completes and ack is still issued.
- fp_rd and fp_wr are never both 1.
- At most one of m0_ack and m1_ack is 1 in any cycle.
- fp_mmio_cs is 1 only in BUS.
- Reset asserted in any state: the next cycle is IDLE with all outputs 0. An in-flight transaction is abandoned with no ack.

Decomposition:
- Package fpro_arb_pkg:
  - state enum type arb_state_t {IDLE, BUS, ACK};
  - localparams for default ADDR_W and DATA_W;
  - master index constants M0=0, M1=1.
- Sub-module rr_arb2:
  - Combinational 2-way grant from req[1:0], last-grant bit, fixed_prio, and a mask input that excludes the just-acked master.
  - The pointer register stays in the top module.

Test Plan:
- Single read: m0_req=1, m0_wr=0, m0_addr=0x00010, mmio returns 0xDEADBEEF.
  - Expect fp_mmio_cs=1, fp_rd=1, fp_addr=0x00010 one cycle after req.
  - Expect m0_ack=1 with m0_rd_data=0xDEADBEEF the cycle after that.
  - m1_ack stays 0.
- Single write: m1 writes 0x0000_00A5 to 0x00200.
  - Expect one cycle of fp_wr=1, fp_rd=0, fp_addr=0x00200, fp_wr_data=0xA5.
  - Expect m1_ack a cycle later; m1_rd_data unchanged.
- Contention, round-robin (FIXED_PRIO=0): both masters hold req continuously, each reissuing immediately after its ack.
  - Expected grant order M0, M1, M0, M1.
  - Strobes on every other cycle (1-cycle BUS/ACK alternation, no IDLE between).
  - Each master sees 2 acks in 8 cycles.
- Contention, fixed priority (FIXED_PRIO=1): same stimulus as round-robin.
  - M1 is granted only in ACK cycles that close an M0 transaction.
  - M0 is never starved.
  - Each transaction still produces exactly one ack.
- Reset mid-transaction: reset=1 during BUS of an m0 read.
  - Next cycle: all fp_* = 0, m0_ack=0, state IDLE.
  - After reset release with m0_req still 1: a fresh transaction completes normally.
- Protocol invariants (assertions across all tests):
  - Never fp_wr & fp_rd.
  - Never m0_ack & m1_ack.
  - fp_mmio_cs is exactly 1 cycle per ack.
